// File: rtl/shared_data_arbiter_pkg.sv
// shared_arb_pkg: state type and elaboration limits shared by the arbiter files
package shared_arb_pkg;
    typedef enum logic {IDLE, SEND} arb_state_t;
    localparam int ARB_MAX_REQ = 16;
endpackage

// File: rtl/shared_data_arbiter_if.sv
// shared_data_arbiter_if: requester/sink bundle; SHARED_ARB_LOCK_EN adds req_lock
interface shared_data_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req_valid, req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic out_valid, out_ready, busy;
    logic [WIDTH-1:0] out_data;
    logic [ID_W-1:0] out_id;
`ifdef SHARED_ARB_LOCK_EN
    logic [NUM_REQ-1:0] req_lock;
    modport master (
        input req_valid, req_data, req_lock, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );
    modport slave (
        output req_valid, req_data, req_lock, out_ready,
        input req_ready, out_valid, out_data, out_id, busy
    );
`else
    modport master (
        input req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );
    modport slave (
        output req_valid, req_data, out_ready,
        input req_ready, out_valid, out_data, out_id, busy
    );
`endif
endinterface

// File: rtl/shared_data_arbiter_rr_picker.sv
// rr_picker: first valid index at or after ptr, wrapping at NUM_REQ-1
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2
) (
    input logic [NUM_REQ-1:0] valid,
    input logic [ID_W-1:0] ptr,
    output logic found,
    output logic [ID_W-1:0] idx
);
    logic [ID_W:0] sum, pos;
    always_comb begin
        found = |valid;
        idx = '0;
        sum = '0;
        pos = '0;
        // descending offsets so the one nearest ptr is written last and wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            pos = sum >= (ID_W + 1)'(NUM_REQ) ? sum - (ID_W + 1)'(NUM_REQ) : sum;
            if (valid[ID_W'(pos)]) idx = ID_W'(pos);
        end
    end
endmodule

// File: rtl/shared_data_arbiter.sv
// shared_data_arbiter: round-robin sharing of one registered data sink among NUM_REQ requesters
// SHARED_ARB_LOCK_EN: a winner with req_lock set keeps priority for its next word
module shared_data_arbiter
    import shared_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 32,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input logic clk,
    input logic rst_n,
    shared_data_arbiter_if.master bus
);
    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
        $error("shared_data_arbiter: NUM_REQ out of range");
    end
    arb_state_t state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt, win;
    logic found, accept, take, hold;
    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .valid(bus.req_valid),
        .ptr(ptr),
        .found(found),
        .idx(win)
    );
`ifdef SHARED_ARB_LOCK_EN
    assign hold = bus.req_lock[win];
`else
    assign hold = 1'b0;
`endif
    // gating with rst_n keeps req_ready low for the whole reset
    assign accept = rst_n && (state == IDLE || (bus.out_valid && bus.out_ready));
    assign take = accept && found;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            bus.out_data <= '0;
            bus.out_id <= '0;
        end else begin
            state <= state_nxt;
            ptr <= ptr_nxt;
            if (take) begin
                bus.out_data <= bus.req_data[int'(win)*WIDTH +: WIDTH];
                bus.out_id <= win;
            end
        end
    end
    always_comb begin
        state_nxt = take ? SEND : accept ? IDLE : state;
        ptr_nxt = !take ? ptr : hold ? win : win == ID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
    end
    always_comb begin
        bus.req_ready = take ? NUM_REQ'(1) << win : '0;
        bus.out_valid = state == SEND;
        bus.busy = state == SEND;
    end
endmodule

// File: tb/tb_shared_data_arbiter.sv
// tb_shared_data_arbiter: directed and random checks of two arbiters (4 and 3 requesters)
module tb_shared_data_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] lka = '0;
    logic [3:0] rdy_a = '0;
    logic [2:0] rdy_b = '0;
    int total = 0;
    int bad = 0;
    int m_ptr[2];
    int m_id[2];
    bit m_full[2];
    logic [7:0] m_data[2];

    always #5 clk = ~clk;

    shared_data_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) ia ();
    shared_data_arbiter_if #(.NUM_REQ(3), .WIDTH(8)) ib ();
    shared_data_arbiter #(.NUM_REQ(4), .WIDTH(8)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
    shared_data_arbiter #(.NUM_REQ(3), .WIDTH(8)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));
`ifdef SHARED_ARB_LOCK_EN
    assign ia.req_lock = lka;
    assign ib.req_lock = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: the spec's rules applied to a word register, a pointer and a fullness flag
    task automatic model(input int k, input int n, input logic [15:0] v, input logic [127:0] d,
                         input logic ordy, input logic [15:0] lk, input logic [15:0] rdy,
                         input logic ov, input logic [7:0] od, input int oid, input logic bz);
        int w;
        bit acc;
        string p;
        logic [15:0] er;
        p = k != 0 ? "b." : "a.";
        w = -1;
        acc = rst_n && (!m_full[k] || ordy);
        for (int j = 0; j < n; j++)
            if (w < 0 && v[(m_ptr[k] + j) % n]) w = (m_ptr[k] + j) % n;
        er = (acc && w >= 0) ? 16'(1) << w : 16'h0;
        chk({p, "req_ready"}, 32'(rdy), 32'(er));
        chk({p, "out_valid"}, 32'(ov), 32'(m_full[k]));
        chk({p, "busy"}, 32'(bz), 32'(m_full[k]));
        chk({p, "out_data"}, 32'(od), 32'(m_data[k]));
        chk({p, "out_id"}, oid, m_id[k]);
        if (!rst_n) begin
            m_full[k] = 0;
            m_data[k] = '0;
            m_id[k] = 0;
            m_ptr[k] = 0;
        end else if (acc) begin
            if (w >= 0) begin
                m_full[k] = 1;
                m_data[k] = d[w*8 +: 8];
                m_id[k] = w;
                m_ptr[k] = lk[w] ? w : (w + 1) % n;
            end else m_full[k] = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model(0, 4, 16'(ia.req_valid), 128'(ia.req_data), ia.out_ready, 16'(lka),
              16'(ia.req_ready), ia.out_valid, ia.out_data, int'(ia.out_id), ia.busy);
        model(1, 3, 16'(ib.req_valid), 128'(ib.req_data), ib.out_ready, 16'h0,
              16'(ib.req_ready), ib.out_valid, ib.out_data, int'(ib.out_id), ib.busy);
        rdy_a = ia.req_ready;
        rdy_b = ib.req_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0;
            m_id[k] = 0;
            m_full[k] = 0;
            m_data[k] = '0;
        end
        ia.req_valid = 4'hf;
        ia.req_data = 32'hA3A2A1A0;
        ia.out_ready = 1'b1;
        ib.req_valid = 3'b111;
        ib.req_data = 24'hC2C1C0;
        ib.out_ready = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(ia.req_ready), 32'h0);
        rst_n = 1'b1;
        ib.req_valid = 3'b101;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_id", 32'(ia.out_id), 32'(i % 4));
            chk("rr_data", 32'(ia.out_data), 32'(8'hA0 + i % 4));
            chk("wrap_id", 32'(ib.out_id), (i % 2) != 0 ? 32'd2 : 32'd0);
        end
        ia.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_id", 32'(ia.out_id), 32'd0);
            chk("bp_data", 32'(ia.out_data), 32'hA0);
            chk("bp_ready", 32'(ia.req_ready), 32'h0);
        end
        ia.out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(ia.req_ready), 32'h2);
        step();
        chk("bp_next_id", 32'(ia.out_id), 32'd1);
        ia.out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("rstmid_valid", 32'(ia.out_valid), 32'd0);
        chk("rstmid_ready", 32'(ia.req_ready), 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++)
                if (rdy_a[i] || !ia.req_valid[i]) begin
                    ia.req_valid[i] = $urandom_range(0, 2) != 0;
                    ia.req_data[i*8 +: 8] = 8'($urandom);
                end
            for (int i = 0; i < 3; i++)
                if (rdy_b[i] || !ib.req_valid[i]) begin
                    ib.req_valid[i] = $urandom_range(0, 2) != 0;
                    ib.req_data[i*8 +: 8] = 8'($urandom);
                end
            ia.out_ready = $urandom_range(0, 3) != 0;
            ib.out_ready = $urandom_range(0, 3) != 0;
            rst_n = $urandom_range(0, 49) != 0;
`ifdef SHARED_ARB_LOCK_EN
            lka = 4'($urandom);
`endif
            step();
        end
`ifdef SHARED_ARB_LOCK_EN
        rst_n = 1'b0;
        ia.req_valid = 4'b0110;
        ia.out_ready = 1'b1;
        lka = 4'b0000;
        step();
        rst_n = 1'b1;
        lka = 4'b0010;
        step();
        chk("lock_id0", 32'(ia.out_id), 32'd1);
        step();
        chk("lock_id1", 32'(ia.out_id), 32'd1);
        lka = 4'b0000;
        step();
        chk("lock_id2", 32'(ia.out_id), 32'd1);
        step();
        chk("lock_id3", 32'(ia.out_id), 32'd2);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
